lcd_cmd_sched: RTL and testbench

//  Command scheduler in front of the LCD image controller. Buffers host commands in a FIFO.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_cmd_sched_if.sv | 22 ++
 rtl/lcd_cmd_fifo.sv | 53 +++++
 rtl/lcd_cmd_sched.sv | 137 +++++++++++++
 tb/tb_lcd_cmd_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, scheduler states and shadow-point helper
package lcd_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    localparam logic [2:0] POS_MIN  = 3'd1;
    localparam logic [2:0] POS_MAX  = 3'd7;
    localparam logic [2:0] POS_INIT = 3'd4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_FINISH,
        ST_HALT
    } sched_state_e;

    // Operation point after a completed command, returned as {x, y}; moves clamp at the edges.
    function automatic logic [5:0] next_point(input logic [2:0] cmd,
                                              input logic [2:0] x,
                                              input logic [2:0] y);
        logic [2:0] nx;
        logic [2:0] ny;
        nx = x;
        ny = y;
        case (cmd)
            CMD_UP:    ny = (y <= POS_MIN) ? POS_MIN : y - 3'd1;
            CMD_DOWN:  ny = (y >= POS_MAX) ? POS_MAX : y + 3'd1;
            CMD_LEFT:  nx = (x <= POS_MIN) ? POS_MIN : x - 3'd1;
            CMD_RIGHT: nx = (x >= POS_MAX) ? POS_MAX : x + 3'd1;
            default: ;
        endcase
        return {nx, ny};
    endfunction

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// rtl/lcd_cmd_sched_if.sv - host command and LCD controller handshake bundle
interface lcd_cmd_sched_if;
    logic [2:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;

    // Host and controller side: supplies commands and controller status.
    modport master (
        output host_cmd, host_valid, lcd_busy, lcd_done,
        input  host_ready, lcd_cmd, lcd_cmd_valid
    );

    // Scheduler side.
    modport slave (
        input  host_cmd, host_valid, lcd_busy, lcd_done,
        output host_ready, lcd_cmd, lcd_cmd_valid
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - DEPTH x 3-bit command FIFO with level output
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [2:0]    push_data_i,
    input  logic          pop_i,
    output logic [2:0]    pop_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    // Pointers wrap naturally because DEPTH is a power of two; level tracks simultaneous push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: an empty level hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// rtl/lcd_cmd_sched.sv - one-at-a-time command issuer in front of the LCD image controller
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    lcd_cmd_sched_if.slave    bus,
    output logic [LW-1:0]     fifo_level,
    output logic [2:0]        pos_x,
    output logic [2:0]        pos_y,
    output logic [CNT_W-1:0]  cmd_count,
    output logic              sched_done,
    output logic              timeout_err
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       lcd_cmd_q, lcd_cmd_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       pos_x_q, pos_x_d;
    logic [2:0]       pos_y_q, pos_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [2:0]       fifo_head;

    // Ready depends only on registered state and level, so a full FIFO refuses a push even in a pop cycle.
    assign bus.host_ready    = ~fifo_full && (state_q != ST_INIT) && (state_q != ST_HALT);
    assign bus.lcd_cmd       = lcd_cmd_q;
    assign bus.lcd_cmd_valid = (state_q == ST_ISSUE);

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign cmd_count   = cnt_q;
    assign sched_done  = done_q;
    assign timeout_err = err_q;

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (bus.host_valid & bus.host_ready),
        .push_data_i (bus.host_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // State and datapath registers; reset drops any queued or in-flight command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            lcd_cmd_q <= CMD_WRITE;
            timer_q   <= '0;
            pos_x_q   <= POS_INIT;
            pos_y_q   <= POS_INIT;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcd_cmd_q <= lcd_cmd_d;
            timer_q   <= timer_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; timer_q holds the number of cycles elapsed since the issue pulse began.
    always_comb begin
        state_d   = state_q;
        lcd_cmd_d = lcd_cmd_q;
        timer_d   = timer_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!bus.lcd_busy) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                timer_d = '0;
                if (!fifo_empty && !bus.lcd_busy) begin
                    fifo_pop  = 1'b1;
                    lcd_cmd_d = fifo_head;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.lcd_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.lcd_busy) begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                    {pos_x_d, pos_y_d} = next_point(lcd_cmd_q, pos_x_q, pos_y_q);
                    state_d = (lcd_cmd_q == CMD_WRITE) ? ST_FINISH : ST_IDLE;
                end
            end
            ST_FINISH: begin
                if (bus.lcd_done) begin
                    done_d  = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: ;
            default: state_d = ST_HALT;
        endcase
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb/tb_lcd_cmd_sched.sv - directed, table-driven bench for lcd_cmd_sched
module tb_lcd_cmd_sched;
    import lcd_pkg::*;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lcd_cmd_sched_if ifc();

    logic [3:0]       fifo_level;
    logic [2:0]       pos_x;
    logic [2:0]       pos_y;
    logic [CNT_W-1:0] cmd_count;
    logic             sched_done;
    logic             timeout_err;

    lcd_cmd_sched #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (ifc),
        .fifo_level  (fifo_level),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .cmd_count   (cmd_count),
        .sched_done  (sched_done),
        .timeout_err (timeout_err)
    );

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic model_done = 1'b0;
    bit   model_stall = 1'b0;
    assign ifc.lcd_busy = force_busy | model_busy;
    assign ifc.lcd_done = model_done;

    // Controller model: busy for 3 cycles per pulse, done 64 cycles after a WRITE's busy falls.
    int         pcnt = 0;
    int         dbl  = 0;
    logic [2:0] plog [0:255];
    int         bcnt = 0;
    int         dcnt = 0;
    logic       prev_valid = 1'b0;
    logic [2:0] last_cmd = 3'd0;
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_busy = 1'b0;
            model_done = 1'b0;
            bcnt = 0;
            dcnt = 0;
            prev_valid = 1'b0;
        end else begin
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    model_busy = 1'b0;
                    if (last_cmd == CMD_WRITE) dcnt = 64;
                end
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) model_done = 1'b1;
            end
            if (ifc.lcd_cmd_valid) begin
                if (prev_valid) dbl++;
                if (pcnt < 256) plog[pcnt] = ifc.lcd_cmd;
                pcnt++;
                last_cmd = ifc.lcd_cmd;
                if (!model_stall) begin
                    model_busy = 1'b1;
                    bcnt = 3;
                end
            end
            prev_valid = ifc.lcd_cmd_valid;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ifc.host_valid = 1'b0;
        force_busy = 1'b0;
        model_stall = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic push(input logic [2:0] c);
        ifc.host_cmd = c;
        ifc.host_valid = 1'b1;
        step(1);
        ifc.host_valid = 1'b0;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (int'(cmd_count) != target && i < budget) begin
            step(1);
            i++;
        end
        check({name, "_count"}, int'(cmd_count), target);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int i;
        i = 0;
        while (ifc.lcd_cmd_valid !== 1'b1 && i < budget) begin
            step(1);
            i++;
        end
        check({name, "_pulse_seen"}, int'(ifc.lcd_cmd_valid), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_host_ready"}, int'(ifc.host_ready), 0);
        check({tag, "_cmd_valid"},  int'(ifc.lcd_cmd_valid), 0);
        check({tag, "_lcd_cmd"},    int'(ifc.lcd_cmd), 0);
        check({tag, "_level"},      int'(fifo_level), 0);
        check({tag, "_pos_x"},      int'(pos_x), 4);
        check({tag, "_pos_y"},      int'(pos_y), 4);
        check({tag, "_count"},      int'(cmd_count), 0);
        check({tag, "_sched_done"}, int'(sched_done), 0);
        check({tag, "_timeout"},    int'(timeout_err), 0);
    endtask

    typedef struct {
        logic [2:0] cmd;
        int         ex;
        int         ey;
        int         ec;
    } vec_t;

    vec_t vt [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int bad;
        int waited;

        vt[0]  = '{CMD_UP,    4, 3, 1};
        vt[1]  = '{CMD_UP,    4, 2, 2};
        vt[2]  = '{CMD_UP,    4, 1, 3};
        vt[3]  = '{CMD_UP,    4, 1, 4};
        vt[4]  = '{CMD_UP,    4, 1, 5};
        vt[5]  = '{CMD_AVG,   4, 1, 6};
        vt[6]  = '{CMD_MIRX,  4, 1, 7};
        vt[7]  = '{CMD_DOWN,  4, 2, 8};
        vt[8]  = '{CMD_LEFT,  3, 2, 9};
        vt[9]  = '{CMD_LEFT,  2, 2, 10};
        vt[10] = '{CMD_LEFT,  1, 2, 11};
        vt[11] = '{CMD_LEFT,  1, 2, 12};
        vt[12] = '{CMD_RIGHT, 2, 2, 13};
        vt[13] = '{CMD_MIRY,  2, 2, 14};
        vt[14] = '{CMD_DOWN,  2, 3, 15};
        vt[15] = '{CMD_DOWN,  2, 4, 16};
        vt[16] = '{CMD_DOWN,  2, 5, 17};
        vt[17] = '{CMD_DOWN,  2, 6, 18};
        vt[18] = '{CMD_DOWN,  2, 7, 19};
        vt[19] = '{CMD_DOWN,  2, 7, 20};

        ifc.host_cmd = 3'd0;
        ifc.host_valid = 1'b0;

        // 1: reset values, controller still loading after release
        reset_n = 1'b0;
        force_busy = 1'b1;
        step(2);
        check_reset_values("t1_reset");
        reset_n = 1'b1;
        bad = 0;
        ifc.host_cmd = CMD_UP;
        ifc.host_valid = 1'b1;
        repeat (70) begin
            step(1);
            if (ifc.host_ready !== 1'b0 || ifc.lcd_cmd_valid !== 1'b0) bad++;
        end
        ifc.host_valid = 1'b0;
        check("t1_init_hold", bad, 0);
        check("t1_init_level", int'(fifo_level), 0);
        force_busy = 1'b0;
        step(1);
        check("t1_ready_after_busy_drop", int'(ifc.host_ready), 1);

        // 2: four RIGHTs queued back to back, x clamps at 7
        do_reset();
        p0 = pcnt;
        for (int i = 0; i < 4; i++) push(CMD_RIGHT);
        wait_count(4, 200, "t2");
        check("t2_pulses", pcnt - p0, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), int'(plog[p0 + i]), int'(CMD_RIGHT));
        check("t2_pos_x", int'(pos_x), 7);
        check("t2_pos_y", int'(pos_y), 4);
        check("t2_double_pulse", dbl, 0);

        // 3: table of single commands with issue latency and shadow point
        do_reset();
        for (int r = 0; r < 20; r++) begin
            check($sformatf("row%0d_ready", r), int'(ifc.host_ready), 1);
            ifc.host_cmd = vt[r].cmd;
            ifc.host_valid = 1'b1;
            step(1);
            ifc.host_valid = 1'b0;
            check($sformatf("row%0d_no_bypass", r), int'(ifc.lcd_cmd_valid), 0);
            step(1);
            check($sformatf("row%0d_pulse", r), int'(ifc.lcd_cmd_valid), 1);
            check($sformatf("row%0d_cmd", r), int'(ifc.lcd_cmd), int'(vt[r].cmd));
            wait_count(vt[r].ec, 50, $sformatf("row%0d", r));
            check($sformatf("row%0d_pos_x", r), int'(pos_x), vt[r].ex);
            check($sformatf("row%0d_pos_y", r), int'(pos_y), vt[r].ey);
            check($sformatf("row%0d_cmd_held", r), int'(ifc.lcd_cmd), int'(vt[r].cmd));
        end
        check("t3_double_pulse", dbl, 0);

        // 4: controller never acknowledges
        do_reset();
        model_stall = 1'b1;
        p0 = pcnt;
        push(CMD_RIGHT);
        wait_valid(10, "t4");
        step(ACK_TIMEOUT - 1);
        check("t4_timeout_not_yet", int'(timeout_err), 0);
        step(1);
        check("t4_timeout_set", int'(timeout_err), 1);
        check("t4_halt_ready", int'(ifc.host_ready), 0);
        push(CMD_LEFT);
        step(20);
        check("t4_no_more_pulses", pcnt - p0, 1);
        check("t4_level", int'(fifo_level), 0);
        check("t4_timeout_sticky", int'(timeout_err), 1);

        // 5: fill while busy, then a refused push in the pop cycle
        do_reset();
        force_busy = 1'b1;
        p0 = pcnt;
        ifc.host_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ifc.host_cmd = 3'((i % 7) + 1);
            step(1);
        end
        check("t5_full_level", int'(fifo_level), 8);
        check("t5_full_ready", int'(ifc.host_ready), 0);
        check("t5_no_pulse_busy", pcnt - p0, 0);
        ifc.host_cmd = CMD_MIRY;
        force_busy = 1'b0;
        step(1);
        ifc.host_valid = 1'b0;
        check("t5_pop_level", int'(fifo_level), 7);
        check("t5_head_pulse", int'(ifc.lcd_cmd_valid), 1);
        check("t5_head_cmd", int'(ifc.lcd_cmd), int'(CMD_UP));
        check("t5_ready_after_pop", int'(ifc.host_ready), 1);

        // 6: WRITE completes and halts with LEFT still queued
        do_reset();
        p0 = pcnt;
        push(CMD_WRITE);
        push(CMD_LEFT);
        waited = 0;
        while (sched_done !== 1'b1 && waited < 300) begin
            step(1);
            waited++;
        end
        check("t6_sched_done", int'(sched_done), 1);
        check("t6_done_latency", waited, 68);
        check("t6_count", int'(cmd_count), 1);
        check("t6_level", int'(fifo_level), 1);
        check("t6_ready", int'(ifc.host_ready), 0);
        step(10);
        check("t6_left_not_issued", pcnt - p0, 1);
        check("t6_issued_write", int'(plog[p0]), int'(CMD_WRITE));
        check("t6_pos_x", int'(pos_x), 4);

        // reset while WRITE is in flight
        do_reset();
        push(CMD_WRITE);
        push(CMD_LEFT);
        step(1);
        check("t6b_busy_inflight", int'(ifc.lcd_busy), 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("t6b_reset");
        step(2);
        reset_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
